// File: rtl/disp_ahb_pkg.sv
// Shared types and constants for the display AHB configuration slave.
//   htrans_e / hresp_e / hsize_e : AHB-Lite encodings used by the slave
//   OFF_* / IDX_*                : register byte offsets and word indices
//   *_RST                        : register reset values
//   ahb_dphase_t                 : address-phase info carried into the data phase
//   lane_strb()                  : byte-lane strobes from HSIZE and HADDR[1:0]
package disp_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_HACT   = 12'h008;
    localparam logic [11:0] OFF_VACT   = 12'h00C;
    localparam logic [11:0] OFF_ISTAT  = 12'h010;
    localparam logic [11:0] OFF_IEN    = 12'h014;
    localparam logic [11:0] OFF_ID     = 12'h018;
    localparam logic [11:0] OFF_LIMIT  = 12'h01C;

    localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
    localparam logic [2:0] IDX_HACT   = OFF_HACT[4:2];
    localparam logic [2:0] IDX_VACT   = OFF_VACT[4:2];
    localparam logic [2:0] IDX_ISTAT  = OFF_ISTAT[4:2];
    localparam logic [2:0] IDX_IEN    = OFF_IEN[4:2];
    localparam logic [2:0] IDX_ID     = OFF_ID[4:2];

    localparam logic [31:0] CTRL_RST = 32'h0000_0000;
    localparam logic [15:0] HACT_RST = 16'd1920;
    localparam logic [15:0] VACT_RST = 16'd1080;

    typedef struct packed {
        logic [4:0] off;
        logic [2:0] size;
    } ahb_dphase_t;

    function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << a;
            HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
            default:    s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/disp_ahb_cfg_regbank.sv
// Register storage for the display configuration slave.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_en/idx/strb    : one-cycle write of wdata into register wr_idx, byte lanes wr_strb
//   rd_idx / rdata    : combinational read mux
//   status_i          : live engine status, read through STATUS
//   irq_set_i         : pulses setting IRQ_STAT bits
//   ctrl_o/hact_o/vact_o/irq_o : register outputs, irq_o registered
module disp_ahb_cfg_regbank
    import disp_ahb_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h0D51_0001
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wdata,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rdata,
    input  logic [31:0] status_i,
    input  logic [7:0]  irq_set_i,
    output logic [31:0] ctrl_o,
    output logic [15:0] hact_o,
    output logic [15:0] vact_o,
    output logic        irq_o
);

    logic [31:0] ctrl_q, ctrl_d;
    logic [15:0] hact_q, hact_d, vact_q, vact_d;
    logic [7:0]  istat_q, istat_d, ien_q, ien_d, w1c;
    logic [31:0] bmask;
    logic        irq_q;

    assign bmask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

    always_comb begin
        ctrl_d = ctrl_q;
        hact_d = hact_q;
        vact_d = vact_q;
        ien_d  = ien_q;
        w1c    = '0;
        if (wr_en) begin
            case (wr_idx)
                IDX_CTRL:  ctrl_d = (ctrl_q & ~bmask) | (wdata & bmask);
                IDX_HACT:  hact_d = (hact_q & ~bmask[15:0]) | (wdata[15:0] & bmask[15:0]);
                IDX_VACT:  vact_d = (vact_q & ~bmask[15:0]) | (wdata[15:0] & bmask[15:0]);
                IDX_ISTAT: w1c    = wdata[7:0] & bmask[7:0];
                IDX_IEN:   ien_d  = (ien_q & ~bmask[7:0]) | (wdata[7:0] & bmask[7:0]);
                default:   ;
            endcase
        end
        // a new event pulse wins over a clear of the same bit
        istat_d = (istat_q & ~w1c) | irq_set_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_RST;
            hact_q  <= HACT_RST;
            vact_q  <= VACT_RST;
            istat_q <= '0;
            ien_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            hact_q  <= hact_d;
            vact_q  <= vact_d;
            istat_q <= istat_d;
            ien_q   <= ien_d;
            irq_q   <= |(istat_q & ien_q);
        end
    end

    // Reads see the post-edge values so a read completing on the same edge
    // as a write to that register returns the new data.
    always_comb begin
        rdata = '0;
        case (rd_idx)
            IDX_CTRL:   rdata = ctrl_d;
            IDX_STATUS: rdata = status_i;
            IDX_HACT:   rdata = {16'h0, hact_d};
            IDX_VACT:   rdata = {16'h0, vact_d};
            IDX_ISTAT:  rdata = {24'h0, istat_d};
            IDX_IEN:    rdata = {24'h0, ien_d};
            IDX_ID:     rdata = ID_VALUE;
            default:    rdata = '0;
        endcase
    end

    assign ctrl_o = ctrl_q;
    assign hact_o = hact_q;
    assign vact_o = vact_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/disp_ahb_cfg_slave.sv
// AHB-Lite subordinate for the display configuration register window.
//   clk, rst_n        : bus clock, synchronous active-low reset
//   HSEL..HWDATA      : AHB-Lite request side (HBURST/HPROT accepted, unused)
//   HRDATA/HREADY/HRESP : registered response; HREADY doubles as HREADYIN
//   status_i, irq_set_i : engine status and interrupt event pulses
//   ctrl_o, hact_o, vact_o, irq_o : configuration outputs
module disp_ahb_cfg_slave
    import disp_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_WAIT   = 1,
    parameter logic [31:0] ID_VALUE  = 32'h0D51_0001
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    input  logic [31:0] status_i,
    input  logic [7:0]  irq_set_i,
    output logic [31:0] ctrl_o,
    output logic [15:0] hact_o,
    output logic [15:0] vact_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RDW, ST_RDD, ST_ERR1, ST_ERR2} state_e;

    localparam logic [1:0] WAIT_LD = (RD_WAIT == 0) ? 2'd0 : 2'(RD_WAIT - 1);

    state_e      state;
    ahb_dphase_t dp_q;
    logic [1:0]  cnt_q;
    logic        accept, addr_err;
    logic [2:0]  rd_idx;
    logic [31:0] rdata;
    logic        unused_in;

    assign unused_in = ^{HBURST, HPROT, HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        if (HADDR[31:12] != BASE_ADDR[31:12])                 addr_err = 1'b1;
        if (HADDR[11:0] >= OFF_LIMIT)                         addr_err = 1'b1;
        if (HSIZE > 3'd2)                                     addr_err = 1'b1;
        if (HSIZE == HSIZE_HALF && HADDR[0])                  addr_err = 1'b1;
        if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)       addr_err = 1'b1;
        if (HWRITE && (HADDR[4:2] == IDX_STATUS || HADDR[4:2] == IDX_ID))
            addr_err = 1'b1;
    end

    // zero-wait reads must sample the register during the address phase
    assign rd_idx = (RD_WAIT == 0) ? HADDR[4:2] : dp_q.off[4:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            HREADY <= 1'b1;
            HRESP  <= HRESP_OKAY;
            HRDATA <= '0;
            dp_q   <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                ST_RDW: begin
                    if (cnt_q == 2'd0) begin
                        state  <= ST_RDD;
                        HREADY <= 1'b1;
                        HRDATA <= rdata;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_ERR1: begin
                    state  <= ST_ERR2;
                    HREADY <= 1'b1;
                    HRESP  <= HRESP_ERROR;
                end
                default: begin
                    // HREADY is high here: any data phase ends on this edge and
                    // the next address phase can be taken in the same cycle.
                    state  <= ST_IDLE;
                    HREADY <= 1'b1;
                    HRESP  <= HRESP_OKAY;
                    if (accept) begin
                        dp_q <= '{off: HADDR[4:0], size: HSIZE};
                        if (addr_err) begin
                            state  <= ST_ERR1;
                            HREADY <= 1'b0;
                            HRESP  <= HRESP_ERROR;
                        end else if (HWRITE) begin
                            state <= ST_WR;
                        end else if (RD_WAIT == 0) begin
                            state  <= ST_RDD;
                            HRDATA <= rdata;
                        end else begin
                            state  <= ST_RDW;
                            HREADY <= 1'b0;
                            cnt_q  <= WAIT_LD;
                        end
                    end
                end
            endcase
        end
    end

    disp_ahb_cfg_regbank #(
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (state == ST_WR),
        .wr_idx    (dp_q.off[4:2]),
        .wr_strb   (lane_strb(dp_q.size, dp_q.off[1:0])),
        .wdata     (HWDATA),
        .rd_idx    (rd_idx),
        .rdata     (rdata),
        .status_i  (status_i),
        .irq_set_i (irq_set_i),
        .ctrl_o    (ctrl_o),
        .hact_o    (hact_o),
        .vact_o    (vact_o),
        .irq_o     (irq_o)
    );

endmodule

// File: tb/tb_disp_ahb_cfg_slave.sv
module tb_disp_ahb_cfg_slave;
    import disp_ahb_pkg::*;

    localparam int RD_WAIT = 1;
    localparam logic [31:0] ID_VAL = 32'h0D51_0001;
    localparam logic [31:0] STAT_VAL = 32'hCAFE_F00D;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    logic        clk, rst_n;
    logic        HSEL, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS, HRESP;
    logic        HREADY;
    logic [31:0] status_i, ctrl_o;
    logic [7:0]  irq_set_i;
    logic [15:0] hact_o, vact_o;
    logic        irq_o;

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
        logic [31:0] mask;
        int          waits;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   dp_act = 1'b0;
    int   waits = 0;

    disp_ahb_cfg_slave #(
        .BASE_ADDR (32'h0000_0000),
        .RD_WAIT   (RD_WAIT),
        .ID_VALUE  (ID_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .status_i(status_i), .irq_set_i(irq_set_i), .ctrl_o(ctrl_o),
        .hact_o(hact_o), .vact_o(vact_o), .irq_o(irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Data-phase monitor: pops the scoreboard when a data phase completes.
    always @(negedge clk) begin
        if (!rst_n) begin
            dp_act = 1'b0;
            waits  = 0;
        end else begin
            if (dp_act) begin
                if (HREADY) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk({mon_e.tag, "_resp"}, 32'(HRESP), mon_e.err ? 32'd1 : 32'd0);
                        chk({mon_e.tag, "_wait"}, 32'(waits), 32'(mon_e.waits));
                        if (mon_e.rd && !mon_e.err)
                            chk({mon_e.tag, "_rdata"}, HRDATA & mon_e.mask, mon_e.data & mon_e.mask);
                    end
                    dp_act = 1'b0;
                end else begin
                    waits++;
                    if (sb.size() != 0 && sb[0].err)
                        chk({sb[0].tag, "_err1"}, 32'(HRESP), 32'd1);
                end
            end
            if (HSEL && HTRANS[1] && HREADY) begin
                dp_act = 1'b1;
                waits  = 0;
            end
        end
    end

    task automatic wait_accept();
        int   n = 0;
        logic r;
        do begin
            @(negedge clk);
            r = HREADY;
            n++;
            @(posedge clk);
        end while (!r && n < 40);
        if (!r) chk("hready_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [1:0] tr, input logic [31:0] wd, input logic [31:0] ed,
                         input logic [31:0] em, input bit err, input string tag, input bit track);
        exp_t e;
        if (track) begin
            e.rd = !w; e.err = err; e.data = ed; e.mask = em; e.tag = tag;
            e.waits = err ? 1 : (w ? 0 : RD_WAIT);
            sb.push_back(e);
        end
        HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = tr;
        wait_accept();
        HWDATA = wd;   // data phase of the transfer just accepted
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr,
                      input logic [31:0] wd, input bit err, input string tag);
        issue(1'b1, a, sz, tr, wd, 32'h0, 32'h0, err, tag, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr,
                      input logic [31:0] ed, input logic [31:0] em, input bit err, input string tag);
        issue(1'b0, a, sz, tr, 32'h0, ed, em, err, tag, 1'b1);
    endtask

    task automatic idle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || dp_act) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        HBURST = 3'b000; HPROT = 4'b0011; HTRANS = HTRANS_IDLE; HWDATA = '0;
        status_i = STAT_VAL; irq_set_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp",  32'(HRESP),  32'd0);
        chk("rst_hrdata", HRDATA,      32'h0);
        chk("rst_ctrl",   ctrl_o,      32'h0);
        chk("rst_hact",   32'(hact_o), 32'd1920);
        chk("rst_vact",   32'(vact_o), 32'd1080);
        chk("rst_irq",    32'(irq_o),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // word write then read with one wait state
        wr(32'h00, HSIZE_WORD, NSEQ, 32'hA5A5_0001, 1'b0, "ctrl_wr");
        rd(32'h00, HSIZE_WORD, NSEQ, 32'hA5A5_0001, 32'hFFFF_FFFF, 1'b0, "ctrl_rd");
        idle(); drain();
        chk("ctrl_o", ctrl_o, 32'hA5A5_0001);

        // byte lane 1 of HACT, then halfword into VACT
        wr(32'h09, HSIZE_BYTE, NSEQ, 32'h0000_FF00, 1'b0, "hact_bwr");
        rd(32'h09, HSIZE_BYTE, NSEQ, 32'h0000_FF00, 32'h0000_FF00, 1'b0, "hact_brd");
        wr(32'h0C, HSIZE_HALF, NSEQ, 32'hFFFF_02D0, 1'b0, "vact_hwr");
        idle(); drain();
        chk("hact_o", 32'(hact_o), 32'h0000_FF80);
        chk("vact_o", 32'(vact_o), 32'h0000_02D0);

        // error responses, issued back to back
        wr(32'h18,   HSIZE_WORD, NSEQ, 32'h1234_5678, 1'b1, "id_wr");
        rd(32'h18,   HSIZE_WORD, NSEQ, ID_VAL, 32'hFFFF_FFFF, 1'b0, "id_rd");
        rd(32'h06,   HSIZE_WORD, NSEQ, 32'h0, 32'h0, 1'b1, "misalign_w");
        rd(32'h20,   HSIZE_WORD, NSEQ, 32'h0, 32'h0, 1'b1, "oor_20");
        rd(32'h1C,   HSIZE_WORD, NSEQ, 32'h0, 32'h0, 1'b1, "oor_1c");
        wr(32'h04,   HSIZE_WORD, NSEQ, 32'hFFFF_FFFF, 1'b1, "status_wr");
        rd(32'h01,   HSIZE_HALF, NSEQ, 32'h0, 32'h0, 1'b1, "misalign_h");
        rd(32'h00,   3'd3,       NSEQ, 32'h0, 32'h0, 1'b1, "bad_size");
        wr(32'h1000, HSIZE_WORD, NSEQ, 32'h0, 1'b1, "base_miss");
        rd(32'h04,   HSIZE_WORD, NSEQ, STAT_VAL, 32'hFFFF_FFFF, 1'b0, "status_rd");
        idle(); drain();
        chk("ctrl_after_err", ctrl_o, 32'hA5A5_0001);

        // interrupt: enable bit 0, pulse, registered output
        wr(32'h14, HSIZE_WORD, NSEQ, 32'h0000_0001, 1'b0, "ien_wr");
        idle(); drain();
        irq_set_i = 8'h01;
        @(posedge clk); #1;
        irq_set_i = 8'h00;
        @(negedge clk);
        chk("irq_lag", 32'(irq_o), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("irq_rise", 32'(irq_o), 32'd1);
        @(posedge clk); #1;

        // clear coinciding with a new pulse: set wins
        wr(32'h10, HSIZE_WORD, NSEQ, 32'h0000_0001, 1'b0, "w1c_race");
        irq_set_i = 8'h01;
        idle();
        @(posedge clk); #1;
        irq_set_i = 8'h00;
        rd(32'h10, HSIZE_WORD, NSEQ, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "istat_kept");
        idle(); drain();
        chk("irq_kept", 32'(irq_o), 32'd1);
        wr(32'h10, HSIZE_WORD, NSEQ, 32'h0000_0001, 1'b0, "w1c_clr");
        rd(32'h10, HSIZE_WORD, NSEQ, 32'h0, 32'hFFFF_FFFF, 1'b0, "istat_clr");
        idle(); drain();
        @(negedge clk);
        chk("irq_fall", 32'(irq_o), 32'd0);
        @(posedge clk); #1;

        // INCR4 write burst over the writable block, then INCR4 read back
        HBURST = 3'b011;
        wr(32'h08, HSIZE_WORD, NSEQ, 32'hDEAD_0500, 1'b0, "bw0");
        wr(32'h0C, HSIZE_WORD, SEQ,  32'hBEEF_0438, 1'b0, "bw1");
        wr(32'h10, HSIZE_WORD, SEQ,  32'hFFFF_FF00, 1'b0, "bw2");
        wr(32'h14, HSIZE_WORD, SEQ,  32'h1234_5602, 1'b0, "bw3");
        rd(32'h08, HSIZE_WORD, NSEQ, 32'h0000_0500, 32'hFFFF_FFFF, 1'b0, "br_hact");
        rd(32'h0C, HSIZE_WORD, SEQ,  32'h0000_0438, 32'hFFFF_FFFF, 1'b0, "br_vact");
        rd(32'h10, HSIZE_WORD, SEQ,  32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "br_istat");
        rd(32'h14, HSIZE_WORD, SEQ,  32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "br_ien");
        rd(32'h00, HSIZE_WORD, NSEQ, 32'hA5A5_0001, 32'hFFFF_FFFF, 1'b0, "br_ctrl");
        rd(32'h04, HSIZE_WORD, SEQ,  STAT_VAL,      32'hFFFF_FFFF, 1'b0, "br_status");
        rd(32'h08, HSIZE_WORD, SEQ,  32'h0000_0500, 32'hFFFF_FFFF, 1'b0, "br_hact2");
        rd(32'h0C, HSIZE_WORD, SEQ,  32'h0000_0438, 32'hFFFF_FFFF, 1'b0, "br_vact2");
        HBURST = 3'b000;

        // back-to-back read after write to the same register
        wr(32'h00, HSIZE_WORD, NSEQ, 32'h1357_9BDF, 1'b0, "raw_wr");
        rd(32'h00, HSIZE_WORD, NSEQ, 32'h1357_9BDF, 32'hFFFF_FFFF, 1'b0, "raw_rd");
        idle(); drain();

        // reset during a read wait state
        issue(1'b0, 32'h00, HSIZE_WORD, NSEQ, 32'h0, 32'h0, 32'h0, 1'b0, "dropped", 1'b0);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        chk("mid_wait_hready", 32'(HREADY), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("mid_rst_hready", 32'(HREADY), 32'd1);
        chk("mid_rst_hresp",  32'(HRESP),  32'd0);
        chk("mid_rst_hrdata", HRDATA,      32'h0);
        chk("mid_rst_ctrl",   ctrl_o,      32'h0);
        chk("mid_rst_hact",   32'(hact_o), 32'd1920);
        chk("mid_rst_vact",   32'(vact_o), 32'd1080);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(32'h08, HSIZE_WORD, NSEQ, 32'd1920, 32'hFFFF_FFFF, 1'b0, "post_rst_rd");
        idle(); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
